// File: rtl/sd_sector_writer_pkg.sv
// Shared constants for the SD sector write path: FSM encoding and default sizes.
package sd_pkg;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int SD_ADDR_W       = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/sd_sector_writer_fifo.sv
// First-word-fall-through byte FIFO; dout always shows the oldest entry while not empty.
module byte_fifo #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == {CW{1'b0}});
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/sd_sector_writer.sv
// Buffers a producer byte stream and emits it as fixed-size sector writes,
// padding the final partial sector when a flush is requested.
module sd_sector_writer
  import sd_pkg::*;
#(
  parameter int         SECTOR_BYTES = SD_SECTOR_BYTES,
  parameter int         FIFO_DEPTH   = 1024,
  parameter logic [7:0] PAD_BYTE     = 8'h00
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_STB,
  input  logic [7:0]           IN_DATA,
  output logic                 IN_ACK,
  input  logic                 FLUSH,
  output logic                 FLUSH_DONE,
  input  logic                 ADDR_LOAD,
  input  logic [SD_ADDR_W-1:0] ADDR_IN,
  output logic                 WR_STB,
  output logic [SD_ADDR_W-1:0] WR_ADDR,
  input  logic                 WR_ACK,
  output logic                 WD_STB,
  output logic [7:0]           WD_DATA,
  input  logic                 WD_ACK,
  output logic                 BUSY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = $clog2(SECTOR_BYTES) + 1;

  logic [1:0]           state_q, state_d;
  logic [SD_ADDR_W-1:0] addr_q, addr_d;
  logic [LW-1:0]        real_len_q, real_len_d;
  logic [LW-1:0]        byte_idx_q, byte_idx_d;
  logic                 flush_q, flush_d;
  logic                 flush_done_q, flush_done_d;

  logic [CW-1:0]        fifo_count;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 in_real;
  logic                 last_byte;
  logic                 sector_ready;

  assign IN_ACK       = RST && !fifo_full;
  assign fifo_push    = IN_STB && IN_ACK;
  assign sector_ready = (fifo_count >= CW'(SECTOR_BYTES));
  assign in_real      = (byte_idx_q < real_len_q);
  assign last_byte    = (byte_idx_q == LW'(SECTOR_BYTES - 1));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (fifo_push),
    .din   (IN_DATA),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sector sequencing: decide when to start a sector, stream it, and finish flushes.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    real_len_d   = real_len_q;
    byte_idx_d   = byte_idx_q;
    flush_d      = flush_q || FLUSH;
    flush_done_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sector_ready) begin
          state_d    = ST_CMD;
          real_len_d = LW'(SECTOR_BYTES);
        end else if (flush_q && (fifo_count != {CW{1'b0}})) begin
          state_d    = ST_CMD;
          real_len_d = LW'(fifo_count);
        end else begin
          if (flush_q) begin
            flush_done_d = 1'b1;
            flush_d      = 1'b0;
          end else begin
            flush_done_d = 1'b0;
          end
          // Address reload is only safe while no sector is being launched.
          if (ADDR_LOAD) begin
            addr_d = ADDR_IN;
          end else begin
            addr_d = addr_q;
          end
        end
      end
      ST_CMD: begin
        if (WR_ACK) begin
          state_d    = ST_DATA;
          byte_idx_d = {LW{1'b0}};
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (WD_ACK) begin
          fifo_pop   = in_real && !fifo_empty;
          byte_idx_d = byte_idx_q + LW'(1);
          if (last_byte) begin
            state_d = ST_IDLE;
            addr_d  = addr_q + SD_ADDR_W'(1);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any sector in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      addr_q       <= {SD_ADDR_W{1'b0}};
      real_len_q   <= {LW{1'b0}};
      byte_idx_q   <= {LW{1'b0}};
      flush_q      <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      real_len_q   <= real_len_d;
      byte_idx_q   <= byte_idx_d;
      flush_q      <= flush_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign FLUSH_DONE = flush_done_q;
  assign BUSY       = (state_q != ST_IDLE);
  assign WR_STB     = (state_q == ST_CMD);
  assign WR_ADDR    = WR_STB ? addr_q : {SD_ADDR_W{1'b0}};
  assign WD_STB     = (state_q == ST_DATA);
  // Past the real length the card still expects a full sector, so fill with padding.
  assign WD_DATA    = WD_STB ? (in_real ? fifo_dout : PAD_BYTE) : 8'h00;

endmodule

// File: tb/tb_sd_sector_writer.sv
// Scoreboard bench for sd_sector_writer with 8-byte sectors and a 16-byte FIFO.
module tb_sd_sector_writer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IN_STB = 1'b0;
  logic [7:0]  IN_DATA = 8'h00;
  logic        IN_ACK;
  logic        FLUSH = 1'b0;
  logic        FLUSH_DONE;
  logic        ADDR_LOAD = 1'b0;
  logic [31:0] ADDR_IN = 32'h0;
  logic        WR_STB;
  logic [31:0] WR_ADDR;
  logic        WR_ACK = 1'b1;
  logic        WD_STB;
  logic [7:0]  WD_DATA;
  logic        WD_ACK = 1'b1;
  logic        BUSY;

  int n_cmp = 0;
  int n_fail = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addr[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  int in_acc = 0;
  int first_stall = -1;
  logic [7:0]  mon_eb;
  logic [31:0] mon_ea;

  sd_sector_writer #(
    .SECTOR_BYTES (8),
    .FIFO_DEPTH   (16),
    .PAD_BYTE     (8'h00)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .IN_STB     (IN_STB),
    .IN_DATA    (IN_DATA),
    .IN_ACK     (IN_ACK),
    .FLUSH      (FLUSH),
    .FLUSH_DONE (FLUSH_DONE),
    .ADDR_LOAD  (ADDR_LOAD),
    .ADDR_IN    (ADDR_IN),
    .WR_STB     (WR_STB),
    .WR_ADDR    (WR_ADDR),
    .WR_ACK     (WR_ACK),
    .WD_STB     (WD_STB),
    .WD_DATA    (WD_DATA),
    .WD_ACK     (WD_ACK),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: every request and data transfer is matched against the expected queues.
  always @(negedge CLK) begin
    if (RST) begin
      if (IN_STB && IN_ACK) in_acc++;
      if (IN_STB && !IN_ACK && first_stall < 0) first_stall = in_acc;
      if (FLUSH_DONE) done_cnt++;
      if (WR_STB && WR_ACK) begin
        wr_cnt++;
        n_cmp++;
        if (exp_addr.size() == 0) begin
          n_fail++;
          $display("FAIL wr_addr: unexpected request, got %h, none expected", WR_ADDR);
        end else begin
          mon_ea = exp_addr.pop_front();
          if (WR_ADDR !== mon_ea) begin
            n_fail++;
            $display("FAIL wr_addr: got %h, expected %h", WR_ADDR, mon_ea);
          end
        end
      end
      if (WD_STB && WD_ACK) begin
        n_cmp++;
        if (exp_bytes.size() == 0) begin
          n_fail++;
          $display("FAIL wd_data: unexpected byte %h, none expected", WD_DATA);
        end else begin
          mon_eb = exp_bytes.pop_front();
          if (WD_DATA !== mon_eb) begin
            n_fail++;
            $display("FAIL wd_data: got %h, expected %h", WD_DATA, mon_eb);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t;
    bit ok;
    t = 0;
    ok = 1'b0;
    IN_STB = 1'b1;
    IN_DATA = b;
    while (!ok && t < 200) begin
      @(negedge CLK);
      if (IN_ACK === 1'b1) ok = 1'b1;
      tick();
      t++;
    end
    IN_STB = 1'b0;
    if (ok) begin
      exp_bytes.push_back(b);
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL push_timeout: byte %h not accepted, required within 200 cycles", b);
    end
  endtask

  task automatic load_addr(input logic [31:0] a);
    ADDR_LOAD = 1'b1;
    ADDR_IN = a;
    tick();
    ADDR_LOAD = 1'b0;
  endtask

  task automatic pulse_flush();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    tick();
    while ((exp_bytes.size() != 0 || BUSY !== 1'b0) && t < budget) begin
      tick();
      t++;
    end
    n_cmp++;
    if (exp_bytes.size() != 0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: %0d bytes outstanding busy=%b, expected 0 and 0", exp_bytes.size(), BUSY);
    end
  endtask

  task automatic test_reset();
    int t;
    int w;
    RST = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if ({IN_ACK, WR_STB, WD_STB, BUSY, FLUSH_DONE} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, expected 00000", {IN_ACK, WR_STB, WD_STB, BUSY, FLUSH_DONE});
    end
    RST = 1'b1;
    tick();
    n_cmp++;
    if (IN_ACK !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ack=%b busy=%b, expected 1 0", IN_ACK, BUSY);
    end
    load_addr(32'h55);
    WD_ACK = 1'b0;
    exp_addr.push_back(32'h55);
    for (int i = 0; i < 8; i++) push_byte(8'hC0 + 8'(i));
    t = 0;
    while (WD_STB !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    n_cmp++;
    if (WD_STB !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reach_data: wd_stb=%b, expected 1", WD_STB);
    end
    RST = 1'b0;
    #1;
    n_cmp++;
    if ({WR_STB, WD_STB, BUSY, IN_ACK, FLUSH_DONE, WD_DATA, WR_ADDR} !== 45'b0) begin
      n_fail++;
      $display("FAIL reset_mid_sector: wr=%b wd=%b busy=%b ack=%b done=%b data=%h addr=%h, expected all 0",
               WR_STB, WD_STB, BUSY, IN_ACK, FLUSH_DONE, WD_DATA, WR_ADDR);
    end
    exp_bytes.delete();
    tick();
    RST = 1'b1;
    WD_ACK = 1'b1;
    w = wr_cnt;
    repeat (4) tick();
    n_cmp++;
    if (BUSY !== 1'b0 || IN_ACK !== 1'b1 || wr_cnt != w) begin
      n_fail++;
      $display("FAIL reset_after: busy=%b in_ack=%b requests=%0d, expected 0 1 0", BUSY, IN_ACK, wr_cnt - w);
    end
    exp_addr.push_back(32'h0);
    for (int i = 0; i < 8; i++) push_byte(8'hD0 + 8'(i));
    wait_idle(100);
  endtask

  task automatic test_full_sector();
    int w;
    load_addr(32'h100);
    exp_addr.push_back(32'h100);
    w = wr_cnt;
    for (int i = 0; i < 8; i++) push_byte(8'(i + 1));
    n_cmp++;
    if (WR_STB !== 1'b0) begin
      n_fail++;
      $display("FAIL full_wr_early: wr_stb=%b, expected 0", WR_STB);
    end
    tick();
    n_cmp++;
    if (WR_STB !== 1'b1 || WR_ADDR !== 32'h100) begin
      n_fail++;
      $display("FAIL full_wr_latency: wr_stb=%b addr=%h, expected 1 00000100", WR_STB, WR_ADDR);
    end
    tick();
    n_cmp++;
    if (WD_STB !== 1'b1 || WD_DATA !== 8'h01) begin
      n_fail++;
      $display("FAIL full_wd_first: wd_stb=%b data=%h, expected 1 01", WD_STB, WD_DATA);
    end
    wait_idle(100);
    n_cmp++;
    if (wr_cnt != w + 1) begin
      n_fail++;
      $display("FAIL full_requests: got %0d, expected 1", wr_cnt - w);
    end
  endtask

  task automatic test_partial_flush();
    int d;
    int w;
    d = done_cnt;
    w = wr_cnt;
    exp_addr.push_back(32'h101);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    for (int i = 0; i < 5; i++) exp_bytes.push_back(8'h00);
    pulse_flush();
    wait_idle(100);
    n_cmp++;
    if (done_cnt != d) begin
      n_fail++;
      $display("FAIL partial_done_early: pulses=%0d, expected 0", done_cnt - d);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt != d + 1 || wr_cnt != w + 1) begin
      n_fail++;
      $display("FAIL partial_done: pulses=%0d requests=%0d, expected 1 1", done_cnt - d, wr_cnt - w);
    end
  endtask

  task automatic test_backpressure();
    int ia;
    int w;
    int d;
    ia = in_acc;
    w = wr_cnt;
    first_stall = -1;
    exp_addr.push_back(32'h102);
    exp_addr.push_back(32'h103);
    WD_ACK = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) push_byte(8'h20 + 8'(i));
      end
      begin
        repeat (18) tick();
        for (int k = 0; k < 60; k++) begin
          tick();
          WD_ACK = ~WD_ACK;
        end
      end
    join
    WD_ACK = 1'b1;
    repeat (10) tick();
    n_cmp++;
    if (first_stall - ia != 16) begin
      n_fail++;
      $display("FAIL bp_full_level: stalled after %0d bytes, expected 16", first_stall - ia);
    end
    n_cmp++;
    if (wr_cnt != w + 2 || exp_bytes.size() != 4 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_sectors: requests=%0d left=%0d busy=%b, expected 2 4 0", wr_cnt - w, exp_bytes.size(), BUSY);
    end
    d = done_cnt;
    exp_addr.push_back(32'h104);
    for (int i = 0; i < 4; i++) exp_bytes.push_back(8'h00);
    pulse_flush();
    wait_idle(100);
    repeat (3) tick();
    n_cmp++;
    if (done_cnt != d + 1) begin
      n_fail++;
      $display("FAIL bp_flush_done: pulses=%0d, expected 1", done_cnt - d);
    end
  endtask

  task automatic test_flush_during_sector();
    int t;
    int d;
    int w;
    exp_addr.push_back(32'h105);
    exp_addr.push_back(32'h106);
    WD_ACK = 1'b0;
    for (int i = 0; i < 10; i++) push_byte(8'h40 + 8'(i));
    t = 0;
    while (WD_STB !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    n_cmp++;
    if (WD_STB !== 1'b1) begin
      n_fail++;
      $display("FAIL fds_reach_data: wd_stb=%b, expected 1", WD_STB);
    end
    d = done_cnt;
    for (int i = 0; i < 6; i++) exp_bytes.push_back(8'h00);
    pulse_flush();
    WD_ACK = 1'b1;
    wait_idle(100);
    n_cmp++;
    if (done_cnt != d) begin
      n_fail++;
      $display("FAIL fds_done_early: pulses=%0d, expected 0", done_cnt - d);
    end
    repeat (3) tick();
    n_cmp++;
    if (done_cnt != d + 1) begin
      n_fail++;
      $display("FAIL fds_done: pulses=%0d, expected 1", done_cnt - d);
    end
    d = done_cnt;
    w = wr_cnt;
    pulse_flush();
    repeat (4) tick();
    n_cmp++;
    if (done_cnt != d + 1 || wr_cnt != w || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_flush: pulses=%0d requests=%0d busy=%b, expected 1 0 0", done_cnt - d, wr_cnt - w, BUSY);
    end
  endtask

  task automatic test_address_wrap();
    int w;
    w = wr_cnt;
    load_addr(32'hFFFF_FFFF);
    exp_addr.push_back(32'hFFFF_FFFF);
    exp_addr.push_back(32'h0000_0000);
    for (int i = 0; i < 16; i++) push_byte(8'h60 + 8'(i));
    wait_idle(200);
    n_cmp++;
    if (wr_cnt != w + 2 || exp_addr.size() != 0) begin
      n_fail++;
      $display("FAIL wrap_requests: got %0d left %0d, expected 2 0", wr_cnt - w, exp_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_full_sector();
    test_partial_flush();
    test_backpressure();
    test_flush_during_sector();
    test_address_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
